// File: rtl/turn_countdown_timer.sv
// Turn countdown timer: loads a budget, counts it down once per PRESCALE clk cycles and pulses expired at 0.
// Outputs are registered, with one edge of latency from the controls. Define TURN_TIMER_AUTORELOAD_EN to re-arm at expiry.
module turn_countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             cancel,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             expired
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pcnt_q,  pcnt_d;
    logic             busy_q,  busy_d;
    logic             tick_q,  tick_d;
    logic             expired_q, expired_d;
`ifdef TURN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q, rld_d;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
`ifdef TURN_TIMER_AUTORELOAD_EN
        rld_d     = rld_q;
`endif

        if (cancel) begin
            // Abort swallows any tick or expiry due this cycle.
            state_d = ST_IDLE;
            count_d = '0;
            pcnt_d  = '0;
        end else if (start) begin
`ifdef TURN_TIMER_AUTORELOAD_EN
            rld_d  = load_val;
`endif
            pcnt_d = '0;
            if (load_val != '0) begin
                count_d = load_val;
                state_d = ST_RUN;
            end else begin
                count_d   = '0;
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (pcnt_q == PCNT_LAST) begin
                        pcnt_d = '0;
                        if (count_q != '0) begin
                            tick_d  = 1'b1;
                            count_d = count_q - WIDTH'(1);
                            if (count_q == WIDTH'(1)) begin
                                expired_d = 1'b1;
`ifdef TURN_TIMER_AUTORELOAD_EN
                                count_d = rld_q;
`else
                                state_d = ST_IDLE;
`endif
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pcnt_q    <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef TURN_TIMER_AUTORELOAD_EN
            rld_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
`ifdef TURN_TIMER_AUTORELOAD_EN
            rld_q     <= rld_d;
`endif
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign tick    = tick_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_turn_countdown_timer.sv
// Bench for turn_countdown_timer: directed turn scenarios plus random control traffic against an elapsed-time model.
module tb_turn_countdown_timer;

    localparam int W = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] load_val;
    logic         pause;
    logic         cancel;
    logic [W-1:0] count;
    logic         busy;
    logic         tick;
    logic         expired;

    turn_countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_val (load_val),
        .pause    (pause),
        .cancel   (cancel),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    // Model: a turn is a budget n and the number of unpaused running cycles
    // elapsed since start; remaining ticks = n - elapsed/P.
    int m_mode;     // 0 idle, 1 running, 2 paused
    int m_n;
    int m_elapsed;
    int m_cnt;
    int m_tick;
    int m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_elapsed = 0; m_cnt = 0; m_tick = 0; m_exp = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        m_exp  = 0;
        if (cancel) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (start) begin
            m_n = int'(load_val);
            m_elapsed = 0;
            if (m_n != 0) begin
                m_mode = 1;
                m_cnt  = m_n;
            end else begin
                m_mode = 0;
                m_cnt  = 0;
                m_exp  = 1;
            end
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2;
            end else begin
                m_elapsed++;
                if (m_elapsed % P == 0) begin
                    m_tick = 1;
                    m_cnt  = m_n - m_elapsed / P;
                    if (m_cnt == 0) begin
                        m_exp = 1;
`ifdef TURN_TIMER_AUTORELOAD_EN
                        m_elapsed = 0;
                        m_cnt     = m_n;
`else
                        m_mode = 0;
`endif
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("count",   32'(count),   32'(m_cnt));
        check("busy",    32'(busy),    32'(m_mode != 0));
        check("tick",    32'(tick),    32'(m_tick));
        check("expired", 32'(expired), 32'(m_exp));
        if (expired === 1'b1) exp_q.push_back(cyc);
    endtask

    task automatic idle_inputs();
        start = 1'b0; load_val = '0; pause = 1'b0; cancel = 1'b0;
    endtask

    // Starts a turn with budget n and returns the edge at which start was sampled.
    task automatic begin_turn(input int n, output int e0);
        start = 1'b1; load_val = W'(n);
        step();
        e0 = cyc;
        start = 1'b0; load_val = '0;
        exp_q.delete();
    endtask

    initial begin
        int e0;
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2;
        check("rst_count",   32'(count),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) step();

        // Budget 3: expiry exactly at edge 12.
        begin_turn(3, e0);
        for (int k = 1; k <= 14; k++) step();
        check("s1_exp_num", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) check("s1_exp_edge", 32'(exp_q[0] - e0), 32'd12);

        // Pause sampled at edges 5..9 pushes expiry to edge 18.
        begin_turn(3, e0);
        for (int k = 1; k <= 20; k++) begin
            pause = (k >= 5 && k <= 9);
            step();
        end
        pause = 1'b0;
        check("s2_exp_num", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) check("s2_exp_edge", 32'(exp_q[0] - e0), 32'd18);

        // Cancel mid-turn: no expiry ever.
        begin_turn(5, e0);
        for (int k = 1; k <= 25; k++) begin
            cancel = (k == 9);
            step();
        end
        cancel = 1'b0;
        check("s3_exp_num", 32'(exp_q.size()), 32'd0);
        check("s3_busy", 32'(busy), 32'd0);

        // Zero budget: immediate one-cycle expiry, never busy.
        start = 1'b1; load_val = '0;
        exp_q.delete();
        step();
        e0 = cyc;
        start = 1'b0;
        repeat (3) step();
        check("s4_exp_num", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) check("s4_exp_edge", 32'(exp_q[0] - e0), 32'd0);

        // Budget 2: expiries at 8 (and 16 when re-arming), cancel at 18.
        begin_turn(2, e0);
        for (int k = 1; k <= 22; k++) begin
            cancel = (k == 18);
            step();
        end
        cancel = 1'b0;
`ifdef TURN_TIMER_AUTORELOAD_EN
        check("s5_exp_num", 32'(exp_q.size()), 32'd2);
        if (exp_q.size() > 1) check("s5_exp_edge2", 32'(exp_q[1] - e0), 32'd16);
`else
        check("s5_exp_num", 32'(exp_q.size()), 32'd1);
`endif
        if (exp_q.size() > 0) check("s5_exp_edge1", 32'(exp_q[0] - e0), 32'd8);

        // Asynchronous reset with count=2: outputs clear before any clk edge.
        begin_turn(4, e0);
        for (int k = 1; k <= 8; k++) step();
        check("s6_pre_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("s6_async_count",   32'(count),   32'd0);
        check("s6_async_busy",    32'(busy),    32'd0);
        check("s6_async_tick",    32'(tick),    32'd0);
        check("s6_async_expired", 32'(expired), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (20) step();
        check("s6_no_exp", 32'(exp_q.size()), 32'd0);

        // Random control traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom_range(0, 15));
            cancel   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            step();
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
